// File: rtl/ahb_slave_mem.sv
// AHB word-memory slave: DEPTH x 32-bit register array behind a BASE-aligned window,
// optional wait states on OKAY data phases and a two-cycle ERROR response outside the window.
module ahb_slave_mem #(
  parameter int unsigned DEPTH       = 512,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [31:0] i_haddr,
  input  logic [1:0]  i_htrans,
  input  logic        i_hwrite,
  input  logic [31:0] i_hwdata,
  input  logic        i_hreadyin,
  output logic        o_hreadyout,
  output logic [31:0] o_hrdata,
  output logic [1:0]  o_hresp
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  localparam logic [1:0] HTRANS_SEQ    = 2'b10;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b11;

  localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  logic [2:0]    r_state;
  logic [2:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic          r_write;
  logic [31:0]   r_mem [DEPTH];

  logic [2:0] w_state_nxt;
  logic [2:0] w_cnt_nxt;
  logic       w_active;
  logic       w_accept;
  logic       w_in_range;

  assign w_active   = (i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ);
  assign w_accept   = w_active && i_hreadyin && o_hreadyout;
  assign w_in_range = (i_haddr[31:AW] == BASE[31:AW]);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_WAIT: begin
        if (r_cnt == 3'd0) w_state_nxt = S_DATA;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
      S_ERR1: w_state_nxt = S_ERR2;
      default: begin
        // S_IDLE, S_DATA and S_ERR2 all end at this edge and may take the next transfer.
        if (!w_accept) begin
          w_state_nxt = S_IDLE;
        end else if (!w_in_range) begin
          w_state_nxt = S_ERR1;
        end else if (WAIT_STATES == 0) begin
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_INIT;
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_addr  <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr  <= i_haddr[AW-1:0];
        r_write <= i_hwrite;
      end
    end
  end

  // No reset on the array; an async reset drops r_state out of S_DATA, which cancels the commit.
  always_ff @(posedge hclk) begin
    if (r_state == S_DATA && r_write) r_mem[r_addr] <= i_hwdata;
  end

  assign o_hreadyout = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
  assign o_hresp     = {1'b0, (r_state == S_ERR1) || (r_state == S_ERR2)};
  assign o_hrdata    = (r_state == S_DATA && !r_write) ? r_mem[r_addr] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: a zero-wait and a two-wait instance share one pipelined master model;
// expected responses are queued at address acceptance and compared when each data phase completes.
module tb_ahb_slave_mem;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SEQ    = 2'b10;
  localparam logic [1:0] NONSEQ = 2'b11;

  typedef struct {
    bit          wr;
    bit          ok;
    logic [8:0]  idx;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          waits;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        sel;

  logic [1:0]  htrans0, htrans2;
  logic        ready0, ready2;
  logic [31:0] rdata0, rdata2;
  logic [1:0]  resp0, resp2;
  logic        rdy;
  logic [31:0] rdata;
  logic [1:0]  resp;

  logic [31:0] mem0 [512];
  logic [31:0] mem2 [512];
  exp_t        sbq [$];

  logic [31:0] xa [16];
  bit          xw [16];
  logic [31:0] xd [16];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 hclk = ~hclk;

  assign htrans0 = sel ? IDLE : htrans;
  assign htrans2 = sel ? htrans : IDLE;
  assign rdy     = sel ? ready2 : ready0;
  assign rdata   = sel ? rdata2 : rdata0;
  assign resp    = sel ? resp2  : resp0;

  ahb_slave_mem #(.DEPTH(512), .BASE(32'h0), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .i_haddr(haddr), .i_htrans(htrans0), .i_hwrite(hwrite),
    .i_hwdata(hwdata), .i_hreadyin(ready0), .o_hreadyout(ready0), .o_hrdata(rdata0),
    .o_hresp(resp0)
  );

  ahb_slave_mem #(.DEPTH(512), .BASE(32'h0), .WAIT_STATES(2)) dut2 (
    .hclk(hclk), .hreset(hreset), .i_haddr(haddr), .i_htrans(htrans2), .i_hwrite(hwrite),
    .i_hwdata(hwdata), .i_hreadyin(ready2), .o_hreadyout(ready2), .o_hrdata(rdata2),
    .o_hresp(resp2)
  );

  // Pipelined master: drives xa/xw/xd[0..n-1] as one burst; abort_at >= 0 pulses reset
  // during the data phase of the beat with that index.
  task automatic run_xfers(input int n, input int abort_at);
    int   ai    = 0;
    int   done  = 0;
    int   waits = 0;
    int   cyc   = 0;
    exp_t e;
    sbq.delete();
    while ((ai < n || sbq.size() > 0) && cyc < 300) begin
      @(posedge hclk);
      #1;
      cyc++;
      if (ai < n) begin
        htrans = (ai == 0) ? NONSEQ : SEQ;
        haddr  = xa[ai];
        hwrite = xw[ai];
      end else begin
        htrans = IDLE;
        haddr  = 32'h0;
        hwrite = 1'b0;
      end
      hwdata = (sbq.size() > 0 && sbq[0].wr) ? sbq[0].wdata : 32'h0;
      if (abort_at >= 0 && done == abort_at && sbq.size() > 0) begin
        #2 hreset = 1'b0;
        #1;
        n_cmp++;
        if ({rdy, resp, rdata} !== {1'b1, 2'b00, 32'h0})
          $display("FAIL reset_mid_burst: ready/resp/rdata=%b/%b/%h required 1/00/00000000",
                   rdy, resp, rdata);
        if ({rdy, resp, rdata} !== {1'b1, 2'b00, 32'h0}) n_bad++;
        sbq.delete();
        htrans = IDLE;
        hwrite = 1'b0;
        @(negedge hclk);
        hreset = 1'b1;
        return;
      end
      @(negedge hclk);
      if (sbq.size() > 0) begin
        if (!rdy) begin
          waits++;
          n_cmp++;
          if (resp !== sbq[0].resp || rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL stall_beat%0d: resp=%b rdata=%h required resp=%b rdata=00000000",
                     done, resp, rdata, sbq[0].resp);
          end
        end else begin
          e = sbq.pop_front();
          n_cmp++;
          if (resp !== e.resp) begin
            n_bad++;
            $display("FAIL resp_beat%0d: got %b required %b", done, resp, e.resp);
          end
          n_cmp++;
          if (rdata !== (e.wr ? 32'h0 : e.rdata)) begin
            n_bad++;
            $display("FAIL rdata_beat%0d: got %h required %h", done, rdata,
                     e.wr ? 32'h0 : e.rdata);
          end
          n_cmp++;
          if (waits !== e.waits) begin
            n_bad++;
            $display("FAIL waits_beat%0d: got %0d required %0d", done, waits, e.waits);
          end
          if (e.wr && e.ok) begin
            if (sel) mem2[e.idx] = e.wdata;
            else     mem0[e.idx] = e.wdata;
          end
          waits = 0;
          done++;
        end
      end
      if (rdy && ai < n) begin
        e.wr    = xw[ai];
        e.ok    = (xa[ai][31:9] == 23'h0);
        e.idx   = xa[ai][8:0];
        e.wdata = xd[ai];
        e.rdata = e.ok ? (sel ? mem2[e.idx] : mem0[e.idx]) : 32'h0;
        e.resp  = e.ok ? 2'b00 : 2'b01;
        e.waits = e.ok ? (sel ? 2 : 0) : 1;
        sbq.push_back(e);
        ai++;
      end
    end
    if (cyc >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: %0d beats done required %0d", done, n);
    end
  endtask

  task automatic test_reset();
    hreset = 1'b0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    n_cmp++;
    if ({ready0, resp0, rdata0} !== {1'b1, 2'b00, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_dut0: ready/resp/rdata=%b/%b/%h required 1/00/00000000",
               ready0, resp0, rdata0);
    end
    n_cmp++;
    if ({ready2, resp2, rdata2} !== {1'b1, 2'b00, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_dut2: ready/resp/rdata=%b/%b/%h required 1/00/00000000",
               ready2, resp2, rdata2);
    end
    hreset = 1'b1;
  endtask

  task automatic test_single();
    sel = 1'b0;
    xa[0] = 32'h2; xw[0] = 1'b1; xd[0] = 32'h2;
    xa[1] = 32'h2; xw[1] = 1'b0; xd[1] = 32'h0;
    run_xfers(2, -1);
  endtask

  task automatic test_burst();
    sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      xa[i] = 32'h100 + 32'(i); xw[i] = 1'b1; xd[i] = 32'h100 + 32'(i);
    end
    run_xfers(8, -1);
    for (int i = 0; i < 8; i++) xw[i] = 1'b0;
    run_xfers(8, -1);
  endtask

  task automatic test_wait_states();
    sel = 1'b1;
    xa[0] = 32'h5; xw[0] = 1'b1; xd[0] = 32'hDEAD_BEEF;
    xa[1] = 32'h5; xw[1] = 1'b0; xd[1] = 32'h0;
    xa[2] = 32'h6; xw[2] = 1'b1; xd[2] = 32'h0BAD_F00D;
    xa[3] = 32'h6; xw[3] = 1'b0; xd[3] = 32'h0;
    xa[4] = 32'h5; xw[4] = 1'b0; xd[4] = 32'h0;
    run_xfers(5, -1);
    sel = 1'b0;
  endtask

  task automatic test_error();
    sel = 1'b0;
    xa[0] = 32'h0;         xw[0] = 1'b1; xd[0] = 32'h1234_5678;
    xa[1] = 32'h0000_1000; xw[1] = 1'b1; xd[1] = 32'hFFFF_FFFF;
    xa[2] = 32'h0;         xw[2] = 1'b0; xd[2] = 32'h0;
    xa[3] = 32'h8000_0003; xw[3] = 1'b0; xd[3] = 32'h0;
    xa[4] = 32'h2;         xw[4] = 1'b0; xd[4] = 32'h0;
    run_xfers(5, -1);
  endtask

  task automatic test_hazard();
    sel = 1'b0;
    xa[0] = 32'h10; xw[0] = 1'b1; xd[0] = 32'hA5A5_0001;
    xa[1] = 32'h10; xw[1] = 1'b0; xd[1] = 32'h0;
    xa[2] = 32'h10; xw[2] = 1'b1; xd[2] = 32'h5A5A_0002;
    xa[3] = 32'h10; xw[3] = 1'b0; xd[3] = 32'h0;
    run_xfers(4, -1);
  endtask

  task automatic test_reset_mid_burst();
    sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      xa[i] = 32'h100 + 32'(i); xw[i] = 1'b1; xd[i] = 32'hBB00_0000 | (32'h100 + 32'(i));
    end
    run_xfers(8, 3);
    for (int i = 0; i < 8; i++) xw[i] = 1'b0;
    run_xfers(8, -1);
  endtask

  initial begin
    sel    = 1'b0;
    htrans = IDLE;
    haddr  = 32'h0;
    hwrite = 1'b0;
    hwdata = 32'h0;
    hreset = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_wait_states();
    test_error();
    test_hazard();
    test_reset_mid_burst();
    repeat (2) @(posedge hclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
